// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK checks, STOP.
// SCL is push-pull; SDA is open-drain and only ever pulled low or released.
module i2c_master_ctrl #(
    parameter int unsigned CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK_A, S_WR_DATA, S_RD_DATA, S_ACK_D, S_STOP
    } state_e;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       wdata_q, wdata_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             rw_q, rw_d;
    logic             samp_q, samp_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             scl_q, scl_d;
    logic             sda_low_q, sda_low_d;
    logic             tick_c;
    logic             sda_in_c;

    assign tick_c   = busy_q && (div_q == DIV_W'(CLK_DIV - 1));
    assign sda_in_c = sda;

    // Next-state logic; bus outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d   = state_q;
        div_d     = '0;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        rw_d      = rw_q;
        samp_d    = samp_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        scl_d     = 1'b1;
        sda_low_d = 1'b0;

        if (busy_q && !tick_c) begin
            div_d = div_q + DIV_W'(1);
        end

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_START;
                qtr_d     = 2'd0;
                bit_d     = 3'd0;
                shift_d   = {dev_addr, rw};
                rw_d      = rw;
                wdata_d   = wdata;
                ack_err_d = 1'b0;
                busy_d    = 1'b1;
            end
        end else if (tick_c) begin
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd2) begin
                samp_d = sda_in_c;
                if (state_q == S_RD_DATA) begin
                    rdata_d = {rdata_q[6:0], sda_in_c};
                end
            end
            if (qtr_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d = S_ADDR;
                        bit_d   = 3'd0;
                    end
                    S_ADDR, S_WR_DATA: begin
                        shift_d = {shift_q[6:0], 1'b0};
                        bit_d   = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = (state_q == S_ADDR) ? S_ACK_A : S_ACK_D;
                        end
                    end
                    S_ACK_A: begin
                        bit_d = 3'd0;
                        if (samp_q) begin
                            ack_err_d = 1'b1;
                            state_d   = S_STOP;
                        end else if (rw_q) begin
                            state_d = S_RD_DATA;
                        end else begin
                            state_d = S_WR_DATA;
                            shift_d = wdata_q;
                        end
                    end
                    S_RD_DATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_d = S_ACK_D;
                        end
                    end
                    S_ACK_D: begin
                        if (!rw_q && samp_q) begin
                            ack_err_d = 1'b1;
                        end
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Bit slots raise SCL in q1-q2; START/STOP move SDA while SCL is high.
        case (state_d)
            S_START: begin
                scl_d     = (qtr_d != 2'd3);
                sda_low_d = (qtr_d >= 2'd2);
            end
            S_ADDR, S_WR_DATA: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                sda_low_d = ~shift_d[7];
            end
            S_ACK_A, S_RD_DATA, S_ACK_D: begin
                scl_d     = (qtr_d == 2'd1) || (qtr_d == 2'd2);
            end
            S_STOP: begin
                scl_d     = (qtr_d != 2'd0);
                sda_low_d = (qtr_d < 2'd2);
            end
            default: begin
                scl_d     = 1'b1;
                sda_low_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
            wdata_q   <= 8'h00;
            rdata_q   <= 8'h00;
            rw_q      <= 1'b0;
            samp_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            scl_q     <= 1'b1;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            rw_q      <= rw_d;
            samp_q    <= samp_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            scl_q     <= scl_d;
            sda_low_q <= sda_low_d;
        end
    end

    assign rdata   = rdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign scl     = scl_q;
    assign sda     = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: open-drain bus with pull-up, a byte-level slave model,
// a protocol watcher, and a done-triggered scoreboard.
module tb_i2c_master_ctrl;

    localparam int unsigned CLK_DIV  = 4;
    localparam logic [6:0]  SLV_ADDR = 7'h2A;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] dev_addr = 7'h00;
    logic       rw = 1'b0;
    logic [7:0] wdata = 8'h00;
    wire  [7:0] rdata;
    wire        busy;
    wire        done;
    wire        ack_err;
    wire        scl;
    wire        sda_bus;
    logic       slave_low = 1'b0;

    assign sda_bus = slave_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dev_addr (dev_addr),
        .rw       (rw),
        .wdata    (wdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .ack_err  (ack_err),
        .scl      (scl),
        .sda      (sda_bus)
    );

    typedef enum int {P_IDLE, P_ADDR, P_AACK, P_WR, P_DACK, P_RD, P_RACK} ph_e;

    typedef struct {
        logic       rw;
        logic       nack;
        logic [7:0] rdata;
        int         lat;
        logic [7:0] addr;
        logic [7:0] wd;
        int         rises;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   dones = 0;
    int   cyc = 0;
    int   t_start = 0;

    ph_e        ph = P_IDLE;
    int         bitn = 0;
    int         rises = 0;
    logic [7:0] sh = 8'h00;
    logic [7:0] addr_got = 8'h00;
    logic [7:0] wr_got = 8'h00;
    logic [7:0] rd_byte = 8'h00;
    logic       in_txn = 1'b0;
    logic       stop_seen = 1'b0;
    logic       master_nack = 1'b0;
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    logic       prev_rst = 1'b1;
    logic       cur_sda;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Bus watcher and slave model; SDA is only moved while SCL is low.
    always @(negedge clk) begin
        cur_sda = sda_bus;
        if (rst || prev_rst) begin
            ph        = P_IDLE;
            in_txn    = 1'b0;
            slave_low = 1'b0;
        end else begin
            if (prev_scl && scl && (cur_sda != prev_sda)) begin
                if (!cur_sda) begin
                    chk("proto_start_inside_txn", 32'(in_txn), 32'd0);
                    in_txn = 1'b1; ph = P_ADDR; bitn = 0; rises = 0;
                    stop_seen = 1'b0; master_nack = 1'b0; addr_got = 8'h00; wr_got = 8'h00;
                end else begin
                    chk("proto_stop_outside_txn", 32'(in_txn), 32'd1);
                    in_txn = 1'b0; stop_seen = 1'b1; ph = P_IDLE; slave_low = 1'b0;
                end
            end
            if (!prev_scl && scl) begin
                rises++;
                case (ph)
                    P_ADDR, P_WR: begin sh = {sh[6:0], cur_sda}; bitn++; end
                    P_RD:         bitn++;
                    P_RACK:       master_nack = cur_sda;
                    default: ;
                endcase
            end
            if (prev_scl && !scl) begin
                case (ph)
                    P_ADDR: if (bitn == 8) begin
                        addr_got = sh;
                        if (sh[7:1] == SLV_ADDR) slave_low = 1'b1;
                        ph = P_AACK;
                    end
                    P_AACK: begin
                        slave_low = 1'b0;
                        bitn = 0;
                        if (addr_got[7:1] != SLV_ADDR) ph = P_IDLE;
                        else if (addr_got[0]) begin ph = P_RD; slave_low = ~rd_byte[7]; end
                        else ph = P_WR;
                    end
                    P_WR: if (bitn == 8) begin wr_got = sh; slave_low = 1'b1; ph = P_DACK; end
                    P_DACK: begin slave_low = 1'b0; ph = P_IDLE; end
                    P_RD: begin
                        if (bitn == 8) begin slave_low = 1'b0; ph = P_RACK; end
                        else slave_low = ~rd_byte[7 - bitn];
                    end
                    P_RACK: ph = P_IDLE;
                    default: ;
                endcase
            end
        end
        prev_scl = scl;
        prev_sda = cur_sda;
        prev_rst = rst;
    end

    // Scoreboard: each done pops one expected transaction.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            dones++;
            chk("sb_expected_entry_at_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("ack_err_at_done", 32'(ack_err), 32'(e.nack));
                chk("rdata_at_done", 32'(rdata), 32'(e.rdata));
                chk("latency_cycles", 32'(cyc - t_start), 32'(e.lat));
                chk("addr_byte_on_bus", 32'(addr_got), 32'(e.addr));
                chk("stop_seen", 32'(stop_seen), 32'd1);
                chk("scl_rises_in_txn", 32'(rises), 32'(e.rises));
                chk("busy_low_at_done", 32'(busy), 32'd0);
                if (!e.rw && !e.nack) chk("wdata_byte_on_bus", 32'(wr_got), 32'(e.wd));
                if (e.rw && !e.nack) chk("master_nack_on_read", 32'(master_nack), 32'd1);
            end
        end
    end

    task automatic push(input logic r, input logic n, input logic [7:0] rd, input int lat,
                        input logic [7:0] a, input logic [7:0] wd, input int ri);
        exp_t e;
        e.rw = r; e.nack = n; e.rdata = rd; e.lat = lat; e.addr = a; e.wd = wd; e.rises = ri;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d);
        @(negedge clk);
        dev_addr = a; rw = r; wdata = d; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_start = cyc;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ack_err_cleared_on_start", 32'(ack_err), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = dones;
        for (int i = 0; i < budget && dones == d0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("done_within_budget", 32'(dones != d0), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rd_byte = 8'hA5;
        repeat (3) @(negedge clk);
        chk("reset_scl", 32'(scl), 32'd1);
        chk("reset_sda", 32'(sda_bus), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_ack_err", 32'(ack_err), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Write 0xC3 to 0x2A
        push(1'b0, 1'b0, 8'h00, 320, 8'h54, 8'hC3, 19);
        issue(7'h2A, 1'b0, 8'hC3);
        wait_done(400);

        // Read 0xA5 from 0x2A
        push(1'b1, 1'b0, 8'hA5, 320, 8'h55, 8'h00, 19);
        issue(7'h2A, 1'b1, 8'h00);
        wait_done(400);

        // Address NACK (no slave at 0x11)
        push(1'b1, 1'b1, 8'hA5, 176, 8'h23, 8'h00, 10);
        issue(7'h11, 1'b1, 8'h00);
        wait_done(400);
        repeat (20) @(negedge clk);
        chk("ack_err_held_after_done", 32'(ack_err), 32'd1);

        // Start while busy must be ignored
        push(1'b0, 1'b0, 8'hA5, 320, 8'h54, 8'h5A, 19);
        issue(7'h2A, 1'b0, 8'h5A);
        repeat (100) @(negedge clk);
        dev_addr = 7'h11; rw = 1'b1; wdata = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(400);
        repeat (400) @(negedge clk);
        chk("dones_after_busy_start", 32'(dones), 32'd4);

        // Reset during the 3rd address bit
        issue(7'h2A, 1'b0, 8'h99);
        repeat (54) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_scl", 32'(scl), 32'd1);
        chk("abort_sda", 32'(sda_bus), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push(1'b0, 1'b0, 8'h00, 320, 8'h54, 8'h0F, 19);
        issue(7'h2A, 1'b0, 8'h0F);
        wait_done(400);

        // Read a second pattern
        rd_byte = 8'h3C;
        push(1'b1, 1'b0, 8'h3C, 320, 8'h55, 8'h00, 19);
        issue(7'h2A, 1'b1, 8'h00);
        wait_done(400);

        repeat (20) @(negedge clk);
        chk("total_dones", 32'(dones), 32'd6);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
